// File: rtl/sram_axi_pkg.sv
// ============================================================================
// sram_axi_pkg : shared IDs, FSM encodings and fixed AXI3 field values
// Revision     : 1.0
// ============================================================================
`default_nettype none

package sram_axi_pkg;

  localparam logic [3:0] ID_INST   = 4'd0;
  localparam logic [3:0] ID_DATA   = 4'd1;
  localparam logic [3:0] AXI_WR_ID = 4'd1;
  localparam logic [7:0] AXI_LEN   = 8'd0;
  localparam logic [1:0] AXI_BURST = 2'b01;
  localparam logic [1:0] AXI_LOCK  = 2'b00;
  localparam logic [3:0] AXI_CACHE = 4'b0000;
  localparam logic [2:0] AXI_PROT  = 3'b000;

  typedef enum logic [0:0] {
    AR_IDLE = 1'b0,
    AR_BUSY = 1'b1
  } ar_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_REQ  = 2'b01,
    W_RESP = 2'b10
  } w_state_e;

  function automatic logic [2:0] axi_size(input logic [1:0] sram_size);
    return {1'b0, sram_size};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_axi_wr_ctrl.sv
// ============================================================================
// sram_axi_wr_ctrl : single-beat AXI3 write engine (AW/W/B) for data writes
// Revision         : 1.0
// ============================================================================
`default_nettype none

module sram_axi_wr_ctrl
  import sram_axi_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic [1:0]  size_i,
  input  logic        awready_i,
  input  logic        wready_i,
  input  logic        bvalid_i,
  output logic        idle_o,
  output logic        awvalid_o,
  output logic [31:0] awaddr_o,
  output logic [2:0]  awsize_o,
  output logic        wvalid_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        bready_o,
  output logic        done_o
);

  w_state_e    state_q, state_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  size_q;

  // AW and W complete independently; W_RESP is entered once both have landed.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    idle_o    = 1'b0;
    awvalid_o = 1'b0;
    wvalid_o  = 1'b0;
    bready_o  = 1'b0;
    done_o    = 1'b0;
    unique case (state_q)
      W_IDLE: begin
        idle_o = 1'b1;
        if (start_i) begin
          state_d   = W_REQ;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      W_REQ: begin
        awvalid_o = ~aw_done_q;
        wvalid_o  = ~w_done_q;
        if (~aw_done_q & awready_i) aw_done_d = 1'b1;
        if (~w_done_q & wready_i)   w_done_d  = 1'b1;
        if (aw_done_d & w_done_d)   state_d   = W_RESP;
      end
      W_RESP: begin
        bready_o = 1'b1;
        if (bvalid_i) begin
          state_d = W_IDLE;
          done_o  = 1'b1;
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= W_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      size_q    <= '0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (start_i && state_q == W_IDLE) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        wstrb_q <= wstrb_i;
        size_q  <= size_i;
      end
    end
  end

  assign awaddr_o = addr_q;
  assign awsize_o = axi_size(size_q);
  assign wdata_o  = wdata_q;
  assign wstrb_o  = wstrb_q;

endmodule

`default_nettype wire

// File: rtl/sram_axi_bridge.sv
// ============================================================================
// sram_axi_bridge : two SRAM-like ports (inst/data) onto one AXI3 master
// Revision        : 1.0
// ============================================================================
`default_nettype none

module sram_axi_bridge
  import sram_axi_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  ar_state_e   ar_state_q, ar_state_d;
  logic        inst_rd_pend_q, inst_rd_pend_d;
  logic        data_rd_pend_q, data_rd_pend_d;
  logic [3:0]  arid_q, arid_d;
  logic [31:0] araddr_q, araddr_d;
  logic [1:0]  arsize_q, arsize_d;

  logic w_idle;
  logic w_done;
  logic ar_free;
  logic data_rd_acc;
  logic data_wr_acc;
  logic inst_rd_acc;
  logic r_inst_hs;
  logic r_data_hs;
  logic unused_inputs;

  assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                           rresp, rlast, bid, bresp};

  // New requests only while both engines idle, which keeps data responses
  // in order and stops a read from overtaking a write still in flight.
  assign ar_free     = resetn & (ar_state_q == AR_IDLE) & w_idle;
  assign data_rd_acc = ar_free & data_sram_req & ~data_sram_wr & ~data_rd_pend_q;
  assign inst_rd_acc = ar_free & inst_sram_req & ~inst_rd_pend_q & ~data_rd_acc;
  assign data_wr_acc = ar_free & data_sram_req & data_sram_wr & ~data_rd_pend_q
                     & ~inst_rd_pend_q & ~inst_rd_acc;

  assign rready    = resetn;
  assign r_inst_hs = rvalid & rready & (rid == ID_INST);
  assign r_data_hs = rvalid & rready & (rid == ID_DATA);

  assign inst_rd_pend_d = (inst_rd_pend_q & ~r_inst_hs) | inst_rd_acc;
  assign data_rd_pend_d = (data_rd_pend_q & ~r_data_hs) | data_rd_acc;

  always_comb begin
    ar_state_d = ar_state_q;
    arid_d     = arid_q;
    araddr_d   = araddr_q;
    arsize_d   = arsize_q;
    unique case (ar_state_q)
      AR_IDLE: begin
        if (data_rd_acc) begin
          ar_state_d = AR_BUSY;
          arid_d     = ID_DATA;
          araddr_d   = data_sram_addr;
          arsize_d   = data_sram_size;
        end else if (inst_rd_acc) begin
          ar_state_d = AR_BUSY;
          arid_d     = ID_INST;
          araddr_d   = inst_sram_addr;
          arsize_d   = inst_sram_size;
        end
      end
      AR_BUSY: begin
        if (arready) ar_state_d = AR_IDLE;
      end
      default: ar_state_d = AR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_state_q     <= AR_IDLE;
      inst_rd_pend_q <= 1'b0;
      data_rd_pend_q <= 1'b0;
      arid_q         <= '0;
      araddr_q       <= '0;
      arsize_q       <= '0;
    end else begin
      ar_state_q     <= ar_state_d;
      inst_rd_pend_q <= inst_rd_pend_d;
      data_rd_pend_q <= data_rd_pend_d;
      arid_q         <= arid_d;
      araddr_q       <= araddr_d;
      arsize_q       <= arsize_d;
    end
  end

  assign arvalid = (ar_state_q == AR_BUSY);
  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arsize  = axi_size(arsize_q);
  assign arlen   = AXI_LEN;
  assign arburst = AXI_BURST;
  assign arlock  = AXI_LOCK;
  assign arcache = AXI_CACHE;
  assign arprot  = AXI_PROT;

  sram_axi_wr_ctrl u_wr_ctrl (
    .clk_i     (clk),
    .rst_n_i   (resetn),
    .start_i   (data_wr_acc),
    .addr_i    (data_sram_addr),
    .wdata_i   (data_sram_wdata),
    .wstrb_i   (data_sram_wstrb),
    .size_i    (data_sram_size),
    .awready_i (awready),
    .wready_i  (wready),
    .bvalid_i  (bvalid),
    .idle_o    (w_idle),
    .awvalid_o (awvalid),
    .awaddr_o  (awaddr),
    .awsize_o  (awsize),
    .wvalid_o  (wvalid),
    .wdata_o   (wdata),
    .wstrb_o   (wstrb),
    .bready_o  (bready),
    .done_o    (w_done)
  );

  assign awid    = AXI_WR_ID;
  assign awlen   = AXI_LEN;
  assign awburst = AXI_BURST;
  assign awlock  = AXI_LOCK;
  assign awcache = AXI_CACHE;
  assign awprot  = AXI_PROT;
  assign wid     = AXI_WR_ID;
  assign wlast   = 1'b1;

  assign inst_sram_addr_ok = inst_rd_acc;
  assign data_sram_addr_ok = data_rd_acc | data_wr_acc;
  assign inst_sram_data_ok = r_inst_hs;
  assign data_sram_data_ok = r_data_hs | w_done;
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

endmodule

`default_nettype wire

// File: tb/tb_sram_axi_bridge.sv
// ============================================================================
// tb_sram_axi_bridge : directed self-checking bench for sram_axi_bridge
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_sram_axi_bridge;

  logic        clk;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int checks   = 0;
  int failures = 0;

  sram_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0000;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h40;
    repeat (2) @(negedge clk);
    checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL rst_arvalid: got %b exp 0", arvalid); end
    checks++; if ({awvalid, wvalid, bready} !== 3'b000) begin failures++; $display("FAIL rst_aw_w_b: got %b exp 000", {awvalid, wvalid, bready}); end
    checks++; if (rready !== 1'b0) begin failures++; $display("FAIL rst_rready: got %b exp 0", rready); end
    checks++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b00) begin failures++; $display("FAIL rst_addr_ok: got %b exp 00", {inst_sram_addr_ok, data_sram_addr_ok}); end
    checks++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin failures++; $display("FAIL rst_data_ok: got %b exp 00", {inst_sram_data_ok, data_sram_data_ok}); end
    step();
    inst_sram_req = 1'b0; data_sram_req = 1'b0; resetn = 1'b1;
    @(negedge clk);
    checks++; if (rready !== 1'b1) begin failures++; $display("FAIL post_rst_rready: got %b exp 1", rready); end
    checks++; if ({awid, wid, wlast} !== 9'b0001_0001_1) begin failures++; $display("FAIL const_ids: got %h/%h/%b exp 1/1/1", awid, wid, wlast); end
  endtask

  task automatic test_inst_read();
    step();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0000; inst_sram_size = 2'd2;
    @(negedge clk);
    checks++; if (inst_sram_addr_ok !== 1'b1) begin failures++; $display("FAIL ir_addr_ok: got %b exp 1", inst_sram_addr_ok); end
    checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL ir_arvalid_early: got %b exp 0", arvalid); end
    step();
    inst_sram_req = 1'b0;
    @(negedge clk);
    checks++; if (arvalid !== 1'b1 || arid !== 4'd0 || araddr !== 32'h1C00_0000) begin failures++; $display("FAIL ir_ar: got v=%b id=%h a=%h exp 1/0/1c000000", arvalid, arid, araddr); end
    checks++; if ({arsize, arlen, arburst, arlock, arcache, arprot} !== {3'd2, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0}) begin failures++; $display("FAIL ir_ar_fields: got sz=%h len=%h bu=%h lk=%h ca=%h pr=%h", arsize, arlen, arburst, arlock, arcache, arprot); end
    step();
    arready = 1'b1;
    @(negedge clk);
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h1C00_0000) begin failures++; $display("FAIL ir_ar_hold: got v=%b a=%h exp 1/1c000000", arvalid, araddr); end
    step();
    arready = 1'b0;
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0004;
    @(negedge clk);
    checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL ir_ar_drop: got %b exp 0", arvalid); end
    checks++; if (inst_sram_addr_ok !== 1'b0) begin failures++; $display("FAIL ir_pend_block: got %b exp 0", inst_sram_addr_ok); end
    step();
    inst_sram_req = 1'b0;
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h0280_0C0C;
    @(negedge clk);
    checks++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'h0280_0C0C) begin failures++; $display("FAIL ir_data: got ok=%b d=%h exp 1/02800c0c", inst_sram_data_ok, inst_sram_rdata); end
    checks++; if (data_sram_data_ok !== 1'b0) begin failures++; $display("FAIL ir_data_misroute: got %b exp 0", data_sram_data_ok); end
    step();
    rvalid = 1'b0;
    @(negedge clk);
    checks++; if (inst_sram_data_ok !== 1'b0) begin failures++; $display("FAIL ir_data_once: got %b exp 0", inst_sram_data_ok); end
  endtask

  task automatic test_simul_reads();
    step();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0004; inst_sram_size = 2'd2;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h100; data_sram_size = 2'd2;
    @(negedge clk);
    checks++; if ({data_sram_addr_ok, inst_sram_addr_ok} !== 2'b10) begin failures++; $display("FAIL sr_arb: got d/i=%b exp 10", {data_sram_addr_ok, inst_sram_addr_ok}); end
    step();
    data_sram_req = 1'b0; arready = 1'b1;
    @(negedge clk);
    checks++; if (arvalid !== 1'b1 || arid !== 4'd1 || araddr !== 32'h100) begin failures++; $display("FAIL sr_ar_data: got v=%b id=%h a=%h exp 1/1/100", arvalid, arid, araddr); end
    checks++; if (inst_sram_addr_ok !== 1'b0) begin failures++; $display("FAIL sr_inst_wait: got %b exp 0", inst_sram_addr_ok); end
    step();
    arready = 1'b0;
    @(negedge clk);
    checks++; if (arvalid !== 1'b0 || inst_sram_addr_ok !== 1'b1) begin failures++; $display("FAIL sr_inst_next: got v=%b ok=%b exp 0/1", arvalid, inst_sram_addr_ok); end
    step();
    inst_sram_req = 1'b0; arready = 1'b1;
    @(negedge clk);
    checks++; if (arvalid !== 1'b1 || arid !== 4'd0 || araddr !== 32'h1C00_0004) begin failures++; $display("FAIL sr_ar_inst: got v=%b id=%h a=%h exp 1/0/1c000004", arvalid, arid, araddr); end
    step();
    arready = 1'b0;
    rvalid = 1'b1; rid = 4'd1; rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (data_sram_data_ok !== 1'b1 || data_sram_rdata !== 32'hDEAD_BEEF || inst_sram_data_ok !== 1'b0) begin failures++; $display("FAIL sr_rdata_data: got dok=%b d=%h iok=%b exp 1/deadbeef/0", data_sram_data_ok, data_sram_rdata, inst_sram_data_ok); end
    step();
    rid = 4'd0; rdata = 32'hCAFE_F00D;
    @(negedge clk);
    checks++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'hCAFE_F00D || data_sram_data_ok !== 1'b0) begin failures++; $display("FAIL sr_rdata_inst: got iok=%b d=%h dok=%b exp 1/cafef00d/0", inst_sram_data_ok, inst_sram_rdata, data_sram_data_ok); end
    step();
    rvalid = 1'b0;
    @(negedge clk);
    checks++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin failures++; $display("FAIL sr_idle: got %b exp 00", {inst_sram_data_ok, data_sram_data_ok}); end
  endtask

  task automatic test_data_write();
    step();
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h8;
    data_sram_wdata = 32'h1234_5678; data_sram_wstrb = 4'hF; data_sram_size = 2'd2;
    @(negedge clk);
    checks++; if (data_sram_addr_ok !== 1'b1 || awvalid !== 1'b0) begin failures++; $display("FAIL dw_accept: got ok=%b awv=%b exp 1/0", data_sram_addr_ok, awvalid); end
    step();
    data_sram_req = 1'b0; data_sram_wr = 1'b0; awready = 1'b1;
    @(negedge clk);
    checks++; if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 32'h8) begin failures++; $display("FAIL dw_req: got awv=%b wv=%b a=%h exp 1/1/8", awvalid, wvalid, awaddr); end
    checks++; if (wdata !== 32'h1234_5678 || wstrb !== 4'hF || awsize !== 3'd2 || awlen !== 8'd0 || awburst !== 2'b01) begin failures++; $display("FAIL dw_fields: got d=%h s=%h sz=%h len=%h bu=%h", wdata, wstrb, awsize, awlen, awburst); end
    step();
    awready = 1'b0;
    @(negedge clk);
    checks++; if (awvalid !== 1'b0 || wvalid !== 1'b1) begin failures++; $display("FAIL dw_aw_done: got awv=%b wv=%b exp 0/1", awvalid, wvalid); end
    step();
    wready = 1'b1;
    @(negedge clk);
    checks++; if (wvalid !== 1'b1 || bready !== 1'b0) begin failures++; $display("FAIL dw_w_wait: got wv=%b br=%b exp 1/0", wvalid, bready); end
    step();
    wready = 1'b0;
    @(negedge clk);
    checks++; if (wvalid !== 1'b0 || bready !== 1'b1 || data_sram_data_ok !== 1'b0) begin failures++; $display("FAIL dw_resp: got wv=%b br=%b ok=%b exp 0/1/0", wvalid, bready, data_sram_data_ok); end
    step();
    bvalid = 1'b1;
    @(negedge clk);
    checks++; if (data_sram_data_ok !== 1'b1) begin failures++; $display("FAIL dw_data_ok: got %b exp 1", data_sram_data_ok); end
    step();
    bvalid = 1'b0;
    @(negedge clk);
    checks++; if (data_sram_data_ok !== 1'b0 || bready !== 1'b0) begin failures++; $display("FAIL dw_done: got ok=%b br=%b exp 0/0", data_sram_data_ok, bready); end
  endtask

  task automatic test_write_blocks_inst();
    step();
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'hC;
    data_sram_wdata = 32'hA5A5_A5A5; data_sram_wstrb = 4'h3; data_sram_size = 2'd1;
    @(negedge clk);
    checks++; if (data_sram_addr_ok !== 1'b1) begin failures++; $display("FAIL wb_accept: got %b exp 1", data_sram_addr_ok); end
    step();
    data_sram_req = 1'b0; data_sram_wr = 1'b0;
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0010; inst_sram_size = 2'd2;
    awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    checks++; if (inst_sram_addr_ok !== 1'b0 || awvalid !== 1'b1 || wvalid !== 1'b1) begin failures++; $display("FAIL wb_req: got iok=%b awv=%b wv=%b exp 0/1/1", inst_sram_addr_ok, awvalid, wvalid); end
    checks++; if (awsize !== 3'd1 || wstrb !== 4'h3) begin failures++; $display("FAIL wb_fields: got sz=%h s=%h exp 1/3", awsize, wstrb); end
    step();
    awready = 1'b0; wready = 1'b0;
    @(negedge clk);
    checks++; if (inst_sram_addr_ok !== 1'b0 || bready !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0) begin failures++; $display("FAIL wb_resp: got iok=%b br=%b awv=%b wv=%b exp 0/1/0/0", inst_sram_addr_ok, bready, awvalid, wvalid); end
    step();
    bvalid = 1'b1;
    @(negedge clk);
    checks++; if (data_sram_data_ok !== 1'b1 || inst_sram_addr_ok !== 1'b0) begin failures++; $display("FAIL wb_bresp: got dok=%b iok=%b exp 1/0", data_sram_data_ok, inst_sram_addr_ok); end
    step();
    bvalid = 1'b0;
    @(negedge clk);
    checks++; if (inst_sram_addr_ok !== 1'b1) begin failures++; $display("FAIL wb_inst_release: got %b exp 1", inst_sram_addr_ok); end
    step();
    inst_sram_req = 1'b0; arready = 1'b1;
    @(negedge clk);
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h1C00_0010) begin failures++; $display("FAIL wb_ar: got v=%b a=%h exp 1/1c000010", arvalid, araddr); end
    step();
    arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h0BAD_F00D;
    @(negedge clk);
    checks++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'h0BAD_F00D) begin failures++; $display("FAIL wb_rdata: got ok=%b d=%h exp 1/0badf00d", inst_sram_data_ok, inst_sram_rdata); end
    step();
    rvalid = 1'b0;
  endtask

  task automatic test_reset_mid();
    step();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0020; inst_sram_size = 2'd2;
    @(negedge clk);
    checks++; if (inst_sram_addr_ok !== 1'b1) begin failures++; $display("FAIL rm_accept: got %b exp 1", inst_sram_addr_ok); end
    step();
    inst_sram_req = 1'b0;
    @(negedge clk);
    checks++; if (arvalid !== 1'b1) begin failures++; $display("FAIL rm_busy: got %b exp 1", arvalid); end
    #2;
    resetn = 1'b0; inst_sram_req = 1'b1;
    #1;
    checks++; if (arvalid !== 1'b0 || rready !== 1'b0 || inst_sram_addr_ok !== 1'b0) begin failures++; $display("FAIL rm_async: got arv=%b rr=%b iok=%b exp 0/0/0", arvalid, rready, inst_sram_addr_ok); end
    step();
    step();
    resetn = 1'b1; inst_sram_addr = 32'h1C00_0030;
    @(negedge clk);
    checks++; if (inst_sram_addr_ok !== 1'b1 || arvalid !== 1'b0) begin failures++; $display("FAIL rm_post_accept: got iok=%b arv=%b exp 1/0", inst_sram_addr_ok, arvalid); end
    step();
    inst_sram_req = 1'b0; arready = 1'b1;
    @(negedge clk);
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h1C00_0030 || arid !== 4'd0) begin failures++; $display("FAIL rm_post_ar: got v=%b a=%h id=%h exp 1/1c000030/0", arvalid, araddr, arid); end
    step();
    arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h1111_2222;
    @(negedge clk);
    checks++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'h1111_2222) begin failures++; $display("FAIL rm_post_r: got ok=%b d=%h exp 1/11112222", inst_sram_data_ok, inst_sram_rdata); end
    step();
    rvalid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd2;
    inst_sram_wstrb = 4'h0; inst_sram_addr = '0; inst_sram_wdata = '0;
    data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd2;
    data_sram_wstrb = 4'h0; data_sram_addr = '0; data_sram_wdata = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b1; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 4'd1; bresp = '0; bvalid = 1'b0;

    test_reset();
    test_inst_read();
    test_simul_reads();
    test_data_write();
    test_write_blocks_inst();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sram_axi_bridge.md
SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

Interface
REQ-001 Parameters: none; all AXI IDs and constants SHALL be fixed values from the shared package.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 inst_sram_{req,wr,size[1:0],wstrb[3:0],addr[31:0],wdata[31:0]}  in  SRAM-like request from fetch; inst_sram_wr is always 0.
REQ-005 inst_sram_{addr_ok,data_ok,rdata[31:0]}  out  SRAM-like response to fetch.
REQ-006 data_sram_{req,wr,size[1:0],wstrb[3:0],addr[31:0],wdata[31:0]}  in  SRAM-like request from execute.
REQ-007 data_sram_{addr_ok,data_ok,rdata[31:0]}  out  SRAM-like response to memory stage.
REQ-008 arid[3:0], araddr[31:0], arlen[7:0], arsize[2:0], arburst[1:0], arlock[1:0], arcache[3:0], arprot[2:0], arvalid  out; arready  in  AXI3 read address channel.
REQ-009 rid[3:0], rdata[31:0], rresp[1:0], rlast, rvalid  in; rready  out  AXI3 read data channel.
REQ-010 awid[3:0], awaddr[31:0], awlen[7:0], awsize[2:0], awburst[1:0], awlock[1:0], awcache[3:0], awprot[2:0], awvalid  out; awready  in  AXI3 write address channel.
REQ-011 wid[3:0], wdata[31:0], wstrb[3:0], wlast, wvalid  out; wready  in  AXI3 write data channel.
REQ-012 bid[3:0], bresp[1:0], bvalid  in; bready  out  AXI3 write response channel.

Function
REQ-013 Constants: arlen=awlen=0, ar/awburst=2'b01, ar/awlock=0, ar/awcache=0, ar/awprot=0, wlast=1, awid=wid=1; ar/awsize={1'b0,latched size}.
REQ-014 Read ID: inst=0, data=1; rid routes response; rresp/bresp ignored.
REQ-015 Read FSM: AR_IDLE -> AR_BUSY on read accept; AR_BUSY holds arvalid and arid/araddr/arsize stable; AR_BUSY -> AR_IDLE on arvalid&arready.
REQ-016 Read accept: addr_ok=1 (combinational) only when AR_IDLE, write FSM in W_IDLE, and no outstanding read for that ID; request latched on same edge.
REQ-017 Data request: accepted only when data read pending flag is 0, together with REQ-016 for reads or REQ-020 for writes.
REQ-018 Arbitration: when inst and data reads are both acceptable in one cycle, data SHALL win; inst addr_ok SHALL be 0.
REQ-019 Pending flags inst_rd_pend/data_rd_pend: set on accept, clear on R handshake; rready=1 whenever resetn=1; x_sram_data_ok=1 for exactly one cycle with x_sram_rdata=rdata on rvalid with matching rid.
REQ-020 Write FSM: W_IDLE -> W_REQ on data write accept (addr_ok=1 only when W_IDLE, AR_IDLE, no read pending, no inst read won); latch addr/wdata/wstrb/size.
REQ-021 W_REQ asserts awvalid and wvalid together; each deasserts independently after its own handshake; -> W_RESP when both are done (same cycle allowed).
REQ-022 W_RESP: bready=1; on bvalid -> W_IDLE and data_sram_data_ok=1 for one cycle.
REQ-023 No read accepted while write FSM is not W_IDLE (RAW ordering); data responses SHALL return in request order.
REQ-024 Inst R and data R/B completions in the same cycle SHALL both be delivered.

Reset
REQ-025 resetn=0 SHALL immediately force AR_IDLE, W_IDLE, pending flags 0, and all valid/ready/addr_ok/data_ok outputs 0; data/address registers 0.
REQ-026 Reset mid-transaction SHALL drop in-flight transfers without completion; the slave is reset simultaneously.

Structure
REQ-027 Package sram_axi_pkg SHALL hold ID constants, AR/W FSM state encodings, and AXI constant field values.
REQ-028 One sub-module, sram_axi_wr_ctrl (AW/W/B FSM), SHALL be instantiated; read path stays in top.

Verification
REQ-029 Inst read addr 0x1C000000, arready after 2 cycles, rdata 0x02800C0C rid=0 -> inst_sram_data_ok=1 once with 0x02800C0C.
REQ-030 Simultaneous inst/data read requests -> data ARID=1 issued first, inst issued next AR_IDLE cycle; both data_ok routed by rid.
REQ-031 Data write addr 0x8, wdata 0x12345678, wstrb 0xF, awready cycle 1, wready cycle 3 -> single W_RESP, data_ok after bvalid only.
REQ-032 Write pending plus inst read req -> inst addr_ok=0 until data_ok of write.
REQ-033 resetn low during AR_BUSY -> arvalid=0 same cycle; post-reset first read issues normally.
